// File: rtl/multi_buffer_sync_manager.sv
// rtl/multi_buffer_sync_manager.sv - ring-buffer writer/reader sync with S2MM command generation
// The writer fills buffers in a ring, issuing one command per buffer; a reader can lock the last full buffer.
module multi_buffer_sync_manager #(
   parameter int MM_ADDR_WIDTH  = 32,
   parameter int NUM_BUFFERS    = 3,
   parameter int LOG_BEAT_BYTES = 0
) (
   input  logic                       SYS_aclk,
   input  logic                       SYS_aresetn,
   input  logic                       SM_beat_valid,
   input  logic                       SM_request,
   input  logic [4:0]                 SM_log_length,
   input  logic [MM_ADDR_WIDTH-1:0]   SM_address,
   output logic [MM_ADDR_WIDTH-1:0]   SM_read_buffer,
   output logic [15:0]                SM_overflow_count,
   input  logic                       M_AXIS_tready,
   output logic                       M_AXIS_tvalid,
   output logic [MM_ADDR_WIDTH+39:0]  M_AXIS_tdata
);

   typedef enum logic {ST_START, ST_RUN} state_t;

   state_t                     state_q, state_d;
   logic [2:0]                 write_idx, full_idx, read_idx;
   logic                       full_valid, locked, req_q;
   logic [MM_ADDR_WIDTH-1:0]   write_addr, full_addr;
   logic [22:0]                beat_cnt;
   logic [4:0]                 cur_log;

   logic [4:0]                 eff_log;
   logic [22:0]                last_beat_cnt;
   logic                       completion, req_rise, protect;
   logic [2:0]                 next_first, next_idx, protect_idx;
   logic [MM_ADDR_WIDTH-1:0]   next_addr;

   function automatic logic [2:0] inc_idx(input logic [2:0] i);
      return (i == 3'(NUM_BUFFERS - 1)) ? 3'd0 : i + 3'd1;
   endfunction

   function automatic logic [MM_ADDR_WIDTH-1:0] buf_addr(input logic [MM_ADDR_WIDTH-1:0] base,
                                                          input logic [2:0] idx,
                                                          input logic [4:0] lg);
      return base + (MM_ADDR_WIDTH'(idx) << lg);
   endfunction

   function automatic logic [MM_ADDR_WIDTH+39:0] make_cmd(input logic [MM_ADDR_WIDTH-1:0] addr,
                                                          input logic [4:0] lg);
      return {4'b0, 4'b0, addr, 1'b0, 1'b0, 6'b0, 1'b1, 23'(23'd1 << lg)};
   endfunction

   always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
      if (!SYS_aresetn) state_q <= ST_START;
      else              state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      eff_log       = SM_log_length;
      last_beat_cnt = ((23'd1 << cur_log) >> LOG_BEAT_BYTES) - 23'd1;
      completion    = 1'b0;
      req_rise      = SM_request && !req_q;
      // A lock taken in the same cycle as a completion must already be honoured by the writer.
      protect       = (locked && SM_request) || (req_rise && full_valid && !locked);
      protect_idx   = locked ? read_idx : full_idx;
      next_first    = inc_idx(write_idx);
      next_idx      = next_first;
      case (state_q)
         ST_START: state_d = ST_RUN;
         ST_RUN: begin
            state_d    = ST_RUN;
            completion = SM_beat_valid && (beat_cnt == last_beat_cnt);
         end
         default: state_d = ST_START;
      endcase
      if (SM_log_length > 5'd22)            eff_log = 5'd22;
      if (eff_log < 5'(LOG_BEAT_BYTES))     eff_log = 5'(LOG_BEAT_BYTES);
      if (protect && next_first == protect_idx) next_idx = inc_idx(next_first);
      next_addr = buf_addr(SM_address, next_idx, eff_log);
   end

   always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
      if (!SYS_aresetn) begin
         write_idx         <= '0;
         full_idx          <= '0;
         read_idx          <= '0;
         full_valid        <= 1'b0;
         locked            <= 1'b0;
         req_q             <= 1'b0;
         write_addr        <= '0;
         full_addr         <= '0;
         beat_cnt          <= '0;
         cur_log           <= '0;
         M_AXIS_tvalid     <= 1'b0;
         M_AXIS_tdata      <= '0;
         SM_read_buffer    <= '0;
         SM_overflow_count <= '0;
      end else begin
         req_q <= SM_request;
         if (state_q == ST_START) begin
            write_idx     <= '0;
            cur_log       <= eff_log;
            write_addr    <= SM_address;
            beat_cnt      <= '0;
            M_AXIS_tdata  <= make_cmd(SM_address, eff_log);
            M_AXIS_tvalid <= 1'b1;
         end else begin
            if (M_AXIS_tvalid && M_AXIS_tready) M_AXIS_tvalid <= 1'b0;
            if (SM_beat_valid) beat_cnt <= completion ? 23'd0 : beat_cnt + 23'd1;
            if (completion) begin
               full_idx      <= write_idx;
               full_addr     <= write_addr;
               full_valid    <= 1'b1;
               write_idx     <= next_idx;
               write_addr    <= next_addr;
               cur_log       <= eff_log;
               M_AXIS_tdata  <= make_cmd(next_addr, eff_log);
               M_AXIS_tvalid <= 1'b1;
               // A pending command that was not taken this cycle is superseded.
               if (M_AXIS_tvalid && !M_AXIS_tready && SM_overflow_count != 16'hFFFF)
                  SM_overflow_count <= SM_overflow_count + 16'd1;
            end
         end
         if (!SM_request) begin
            locked         <= 1'b0;
            SM_read_buffer <= '0;
         end else if (req_rise && full_valid && !locked) begin
            locked         <= 1'b1;
            read_idx       <= full_idx;
            SM_read_buffer <= full_addr;
         end
      end
   end

endmodule

// File: tb/tb_multi_buffer_sync_manager.sv
// tb/tb_multi_buffer_sync_manager.sv - directed self-checking bench for multi_buffer_sync_manager
module tb_multi_buffer_sync_manager;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        beat_valid;
   logic        request;
   logic [4:0]  log_length;
   logic [31:0] address;
   logic [31:0] read_buffer;
   logic [15:0] overflow_count;
   logic        tready;
   logic        tvalid;
   logic [71:0] tdata;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   multi_buffer_sync_manager dut (
      .SYS_aclk          (clk),
      .SYS_aresetn       (rst_n),
      .SM_beat_valid     (beat_valid),
      .SM_request        (request),
      .SM_log_length     (log_length),
      .SM_address        (address),
      .SM_read_buffer    (read_buffer),
      .SM_overflow_count (overflow_count),
      .M_AXIS_tready     (tready),
      .M_AXIS_tvalid     (tvalid),
      .M_AXIS_tdata      (tdata)
   );

   function automatic logic [71:0] cmd(input logic [31:0] addr, input logic [22:0] btt);
      return {8'h00, addr, 9'b0_0_000000_1, btt};
   endfunction

   task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic beats(input int n);
      for (int i = 0; i < n; i++) begin
         beat_valid = 1'b1;
         @(negedge clk);
      end
      beat_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; beat_valid = 1'b0; request = 1'b0; tready = 1'b1;
      log_length = 5'd4; address = 32'h1000_0000;
      @(negedge clk); @(negedge clk);
      check("rst_tvalid", 72'(tvalid), 72'(1'b0));
      check("rst_tdata", tdata, 72'h0);
      check("rst_read_buffer", 72'(read_buffer), 72'h0);
      check("rst_overflow", 72'(overflow_count), 72'h0);

      rst_n = 1'b1;
      @(negedge clk);
      check("start_tvalid", 72'(tvalid), 72'(1'b1));
      check("start_cmd", tdata, cmd(32'h1000_0000, 23'd16));
      @(negedge clk);
      check("start_accept_drop", 72'(tvalid), 72'(1'b0));

      beats(16);
      check("buf1_tvalid", 72'(tvalid), 72'(1'b1));
      check("buf1_cmd", tdata, cmd(32'h1000_0010, 23'd16));
      beats(16);
      check("buf2_cmd", tdata, cmd(32'h1000_0020, 23'd16));
      beats(16);
      check("wrap_buf0_cmd", tdata, cmd(32'h1000_0000, 23'd16));

      beats(32);
      check("pre_lock_cmd", tdata, cmd(32'h1000_0020, 23'd16));
      request = 1'b1;
      @(negedge clk);
      check("lock_read_buffer", 72'(read_buffer), 72'h1000_0010);
      beats(16);
      check("locked_w0_cmd", tdata, cmd(32'h1000_0000, 23'd16));
      beats(16);
      check("locked_skip_cmd", tdata, cmd(32'h1000_0020, 23'd16));
      check("lock_stable", 72'(read_buffer), 72'h1000_0010);
      beats(16);
      check("locked_w0_again", tdata, cmd(32'h1000_0000, 23'd16));
      request = 1'b0;
      @(negedge clk);
      check("unlock_read_buffer", 72'(read_buffer), 72'h0);

      tready = 1'b0;
      beats(48);
      check("ovf_tvalid", 72'(tvalid), 72'(1'b1));
      check("ovf_latest_cmd", tdata, cmd(32'h1000_0000, 23'd16));
      check("ovf_count", 72'(overflow_count), 72'd2);
      @(negedge clk);
      check("ovf_tvalid_held", 72'(tvalid), 72'(1'b1));
      tready = 1'b1;
      @(negedge clk);
      check("ovf_accept_drop", 72'(tvalid), 72'(1'b0));

      tready = 1'b0;
      beats(16);
      check("same_pre_cmd", tdata, cmd(32'h1000_0010, 23'd16));
      beats(15);
      tready = 1'b1;
      beats(1);
      check("same_cycle_cmd", tdata, cmd(32'h1000_0020, 23'd16));
      check("same_cycle_no_ovf", 72'(overflow_count), 72'd2);
      check("same_cycle_tvalid", 72'(tvalid), 72'(1'b1));
      @(negedge clk);
      check("same_cycle_drop", 72'(tvalid), 72'(1'b0));

      beats(8);
      log_length = 5'd5;
      beats(8);
      check("midbuf_len_cmd", tdata, cmd(32'h1000_0000, 23'd32));
      beats(16);
      check("len32_no_completion", 72'(tvalid), 72'(1'b0));
      beats(16);
      check("len32_cmd", tdata, cmd(32'h1000_0020, 23'd32));
      log_length = 5'd31;
      beats(32);
      check("clamp_cmd", tdata, cmd(32'h1080_0000, 23'h40_0000));

      request = 1'b1;
      @(negedge clk);
      check("lock2_read_buffer", 72'(read_buffer), 72'h1000_0020);
      beats(5);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_tvalid", 72'(tvalid), 72'(1'b0));
      check("async_rst_tdata", tdata, 72'h0);
      check("async_rst_read_buffer", 72'(read_buffer), 72'h0);
      check("async_rst_overflow", 72'(overflow_count), 72'h0);
      log_length = 5'd4;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rerun_start_tvalid", 72'(tvalid), 72'(1'b1));
      check("rerun_start_cmd", tdata, cmd(32'h1000_0000, 23'd16));
      check("rerun_no_lock", 72'(read_buffer), 72'h0);
      @(negedge clk);
      beats(16);
      check("rerun_buf1_cmd", tdata, cmd(32'h1000_0010, 23'd16));
      check("held_request_no_lock", 72'(read_buffer), 72'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
